// File: rtl/sync_deglitch.sv
// sync_deglitch: per-channel multi-flop synchronizer for asynchronous level inputs.
// An optional stability filter follows the chain. Rise and fall pulses are
// generated from the filtered level. Each channel is independent, so a
// multi-bit value carried on several channels is not kept coherent.
module sync_deglitch #(
  parameter int unsigned      WIDTH        = 1,
  parameter int unsigned      STAGES       = 2,
  parameter logic [WIDTH-1:0] ResetValue   = '0,
  parameter int unsigned      FilterCycles = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] serial_i,
  output logic [WIDTH-1:0] serial_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // A two-flop chain is the minimum that gives the first flop a full cycle to resolve metastability.
  if (STAGES < 2) begin : gen_stages_check
    $error("sync_deglitch: STAGES must be at least 2");
  end
  if (WIDTH < 1) begin : gen_width_check
    $error("sync_deglitch: WIDTH must be at least 1");
  end

  // Synchronizer chain. Only sync_q[0] samples the asynchronous pins.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_level;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] edge_q;

  // Shift every channel through the synchronizer flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= ResetValue;
      end
    end else begin
      sync_q[0] <= serial_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_level = sync_q[STAGES-1];

  if (FilterCycles == 0) begin : gen_bypass
    // No filter: the synchronized level is the accepted level.
    assign level = sync_level;
  end else begin : gen_filter
    // The counter only ever holds 0..FilterCycles-1, so it never wraps.
    localparam int unsigned     CntW    = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;

    // A new level is accepted only after it has held for FilterCycles consecutive cycles.
    // Any return to the current level restarts the count.
    always_comb begin
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = cnt_q[i];
        if (sync_level[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          level_d[i] = sync_level[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end

    // Register the filtered level and the per-channel stability counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_q <= ResetValue;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        level_q <= level_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign level = level_q;
  end

  // Edge history: the accepted level one cycle ago.
  // Resetting it to ResetValue suppresses a pulse for the reset-induced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= ResetValue;
    end else begin
      edge_q <= level;
    end
  end

  // The pulses are decoded from flop outputs only, so they are glitch-free.
  // Rise and fall are mutually exclusive by construction.
  assign serial_o = level;
  assign rise_o   = level & ~edge_q;
  assign fall_o   = ~level & edge_q;

endmodule

// File: tb/tb_sync_deglitch.sv
// tb_sync_deglitch: directed bench for sync_deglitch.
// Four instances cover the bypass, filtered, wide and reset-value configurations.
// Expected values are queued with the cycle at which they become due.
// A negedge monitor pops each entry when its cycle comes and compares it.
// Every cycle, the monitor also checks that the pulses agree with level history.
module tb_sync_deglitch;

  typedef struct {
    int         due;
    int         which;
    logic [7:0] expv;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] inA, outA, riseA, fallA;
  logic [7:0] inB, outB, riseB, fallB;
  logic [0:0] inC, outC, riseC, fallC;
  logic [0:0] inD, outD, riseD, fallD;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic       prevRstN = 1'b0;
  logic [7:0] prevA, prevB, prevC, prevD;

  sync_deglitch #(.WIDTH(4), .STAGES(2), .ResetValue(4'b1010), .FilterCycles(0)) dutA (
    .clk_i(clk), .rst_ni(rstN), .serial_i(inA), .serial_o(outA), .rise_o(riseA), .fall_o(fallA));
  sync_deglitch #(.WIDTH(8), .STAGES(3), .ResetValue(8'h00), .FilterCycles(0)) dutB (
    .clk_i(clk), .rst_ni(rstN), .serial_i(inB), .serial_o(outB), .rise_o(riseB), .fall_o(fallB));
  sync_deglitch #(.WIDTH(1), .STAGES(2), .ResetValue(1'b0), .FilterCycles(4)) dutC (
    .clk_i(clk), .rst_ni(rstN), .serial_i(inC), .serial_o(outC), .rise_o(riseC), .fall_o(fallC));
  sync_deglitch #(.WIDTH(1), .STAGES(2), .ResetValue(1'b0), .FilterCycles(8)) dutD (
    .clk_i(clk), .rst_ni(rstN), .serial_i(inD), .serial_o(outD), .rise_o(riseD), .fall_o(fallD));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input int which);
    case (which)
      0:       return {4'b0, outA};
      1:       return {4'b0, riseA};
      2:       return {4'b0, fallA};
      3:       return outB;
      4:       return riseB;
      5:       return fallB;
      6:       return {7'b0, outC};
      7:       return {7'b0, riseC};
      8:       return {7'b0, fallC};
      9:       return {7'b0, outD};
      10:      return {7'b0, riseD};
      11:      return {7'b0, fallD};
      default: return 8'hxx;
    endcase
  endfunction

  // Queue an expected value for observable `which`, due `offset` cycles from now.
  task automatic checkOutput(input string tag, input int which, input int offset, input logic [7:0] expv);
    sb.push_back('{due: cyc + offset, which: which, expv: expv, tag: tag});
  endtask

  // Drive all inputs just after the next rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] b, input logic c, input logic d);
    @(posedge clk);
    #1;
    inA = a;
    inB = b;
    inC = c;
    inD = d;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Pulses must match the change of the level since the last sample, and rise and fall must never coincide.
  task automatic checkPulse(input string tag, input logic [7:0] lvl, input logic [7:0] prev,
                            input logic [7:0] rise, input logic [7:0] fall);
    total++;
    assert (rise === (lvl & ~prev)) else begin
      bad++;
      $error("FAIL %s_rise observed=%h expected=%h", tag, rise, lvl & ~prev);
    end
    total++;
    assert (fall === (~lvl & prev)) else begin
      bad++;
      $error("FAIL %s_fall observed=%h expected=%h", tag, fall, ~lvl & prev);
    end
    total++;
    assert ((rise & fall) === 8'h00) else begin
      bad++;
      $error("FAIL %s_both observed=%h expected=00", tag, rise & fall);
    end
  endtask

  // Scoreboard pop and per-cycle pulse checks, sampled away from the active edge.
  always @(negedge clk) begin
    logic [7:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        obs = observe(sb[i].which);
        total++;
        assert ((sb[i].due == cyc) && (obs === sb[i].expv)) else begin
          bad++;
          $error("FAIL %s observed=%h expected=%h cycle=%0d", sb[i].tag, obs, sb[i].expv, sb[i].due);
        end
        sb.delete(i);
      end
    end
    if (rstN && prevRstN) begin
      checkPulse("pulseA", {4'b0, outA}, prevA, {4'b0, riseA}, {4'b0, fallA});
      checkPulse("pulseB", outB, prevB, riseB, fallB);
      checkPulse("pulseC", {7'b0, outC}, prevC, {7'b0, riseC}, {7'b0, fallC});
      checkPulse("pulseD", {7'b0, outD}, prevD, {7'b0, riseD}, {7'b0, fallD});
    end
    prevA    = {4'b0, outA};
    prevB    = outB;
    prevC    = {7'b0, outC};
    prevD    = {7'b0, outD};
    prevRstN = rstN;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    inA = 4'b1010;
    inB = 8'h00;
    inC = 1'b0;
    inD = 1'b0;

    // Reset state, held during reset and for 10 cycles after release.
    waitCycles(3);
    #1;
    checkOutput("rst_outA", 0, 0, 8'h0A);
    checkOutput("rst_riseA", 1, 0, 8'h00);
    checkOutput("rst_fallA", 2, 0, 8'h00);
    checkOutput("rst_outB", 3, 0, 8'h00);
    checkOutput("rst_outC", 6, 0, 8'h00);
    rstN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      checkOutput("post_rst_outA", 0, i, 8'h0A);
      checkOutput("post_rst_riseA", 1, i, 8'h00);
      checkOutput("post_rst_fallA", 2, i, 8'h00);
    end
    waitCycles(12);

    // Latency through three stages, bypassed filter.
    applyStimulus(4'b1010, 8'h01, 1'b0, 1'b0);
    checkOutput("lat_pre", 3, 2, 8'h00);
    checkOutput("lat_out", 3, 3, 8'h01);
    checkOutput("lat_rise", 4, 3, 8'h01);
    checkOutput("lat_fall", 5, 3, 8'h00);
    checkOutput("lat_rise_end", 4, 4, 8'h00);
    waitCycles(6);
    applyStimulus(4'b1010, 8'h00, 1'b0, 1'b0);
    checkOutput("lat_fall_back", 5, 3, 8'h01);
    checkOutput("lat_out_back", 3, 3, 8'h00);
    waitCycles(6);

    // Multi-channel simultaneous changes.
    applyStimulus(4'b1010, 8'hA5, 1'b0, 1'b0);
    checkOutput("multi_pre", 3, 2, 8'h00);
    checkOutput("multi_out", 3, 3, 8'hA5);
    checkOutput("multi_rise", 4, 3, 8'hA5);
    checkOutput("multi_fall", 5, 3, 8'h00);
    checkOutput("multi_rise_end", 4, 4, 8'h00);
    waitCycles(6);
    applyStimulus(4'b1010, 8'h5A, 1'b0, 1'b0);
    checkOutput("swap_pre", 3, 2, 8'hA5);
    checkOutput("swap_out", 3, 3, 8'h5A);
    checkOutput("swap_rise", 4, 3, 8'h5A);
    checkOutput("swap_fall", 5, 3, 8'hA5);
    checkOutput("swap_fall_end", 5, 4, 8'h00);
    waitCycles(6);

    // Glitch of 3 periods is rejected by the 4-cycle filter.
    applyStimulus(4'b1010, 8'h5A, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      checkOutput("glitch_out", 6, i, 8'h00);
      checkOutput("glitch_rise", 7, i, 8'h00);
    end
    waitCycles(2);
    applyStimulus(4'b1010, 8'h5A, 1'b0, 1'b0);
    waitCycles(12);

    // A 6-period pulse is accepted after STAGES+4 edges, then falls at the same latency.
    applyStimulus(4'b1010, 8'h5A, 1'b1, 1'b0);
    checkOutput("hold_pre", 6, 5, 8'h00);
    checkOutput("hold_out", 6, 6, 8'h01);
    checkOutput("hold_rise", 7, 6, 8'h01);
    checkOutput("hold_rise_end", 7, 7, 8'h00);
    waitCycles(5);
    applyStimulus(4'b1010, 8'h5A, 1'b0, 1'b0);
    checkOutput("hold_low_pre", 6, 5, 8'h01);
    checkOutput("hold_low_out", 6, 6, 8'h00);
    checkOutput("hold_fall", 8, 6, 8'h01);
    waitCycles(10);

    // Restart: high 3, low 1, high again; only the second run is accepted.
    applyStimulus(4'b1010, 8'h5A, 1'b1, 1'b0);
    waitCycles(2);
    applyStimulus(4'b1010, 8'h5A, 1'b0, 1'b0);
    applyStimulus(4'b1010, 8'h5A, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      checkOutput("restart_hold", 6, i, 8'h00);
    end
    checkOutput("restart_out", 6, 6, 8'h01);
    checkOutput("restart_rise", 7, 6, 8'h01);
    waitCycles(8);
    applyStimulus(4'b1010, 8'h5A, 1'b0, 1'b0);
    checkOutput("restart_fall", 8, 6, 8'h01);
    waitCycles(10);

    // Reset during filtering discards the count and forces outputs to ResetValue immediately.
    applyStimulus(4'b0101, 8'h5A, 1'b0, 1'b1);
    checkOutput("mid_outA", 0, 2, 8'h05);
    waitCycles(7);
    #1;
    rstN = 1'b0;
    checkOutput("mid_rst_outA", 0, 0, 8'h0A);
    checkOutput("mid_rst_riseA", 1, 0, 8'h00);
    checkOutput("mid_rst_fallA", 2, 0, 8'h00);
    checkOutput("mid_rst_outD", 9, 0, 8'h00);
    checkOutput("mid_rst_outB", 3, 0, 8'h00);
    checkOutput("mid_rst_outA1", 0, 1, 8'h0A);
    waitCycles(2);
    #1;
    rstN = 1'b1;
    checkOutput("rel_outA", 0, 2, 8'h05);
    checkOutput("rel_riseA", 1, 2, 8'h05);
    checkOutput("rel_fallA", 2, 2, 8'h0A);
    for (int i = 1; i <= 9; i++) begin
      checkOutput("rel_holdD", 9, i, 8'h00);
    end
    checkOutput("rel_outD", 9, 10, 8'h01);
    checkOutput("rel_riseD", 10, 10, 8'h01);
    checkOutput("rel_riseD_end", 10, 11, 8'h00);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d pending expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
